// File: rtl/bus_arbiter_pkg.sv
// Shared cache-side definitions: arbiter state encodings and default geometry.
// Imported by the bus arbiter and the cache controller.
package bus_arbiter_pkg;

    localparam logic [2:0] Q_IDLE = 3'b001;
    localparam logic [2:0] Q_GNT0 = 3'b010;
    localparam logic [2:0] Q_GNT1 = 3'b100;

    localparam int unsigned ADDR_W_DEF  = 5;
    localparam int unsigned DATA_W_DEF  = 16;
    localparam int unsigned TIMEOUT_DEF = 15;

    // Grant-cycle counter must hold TIMEOUT and is never narrower than 4 bits.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return ($clog2(timeout + 1) > 4) ? $clog2(timeout + 1) : 4;
    endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Two-requester round-robin arbiter in front of a single memory port, with
// one idle turnaround cycle between grants and a per-grant completion timeout.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_rd_0,
    input  logic              bus_wr_0,
    input  logic [ADDR_W-1:0] bus_addr_0,
    input  logic [DATA_W-1:0] bus_dout_0,
    output logic [DATA_W-1:0] bus_din_0,
    output logic              bus_done_0,
    input  logic              bus_rd_1,
    input  logic              bus_wr_1,
    input  logic [ADDR_W-1:0] bus_addr_1,
    input  logic [DATA_W-1:0] bus_dout_1,
    output logic [DATA_W-1:0] bus_din_1,
    output logic              bus_done_1,
    output logic              memread,
    output logic              memwrite,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    input  logic              mem_done,
    output logic [1:0]        gnt,
    output logic              err_timeout
);

    localparam int unsigned CNT_W = cnt_width(TIMEOUT);

    logic [2:0]       state, state_nxt;
    logic             rr, rr_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             err_nxt;
    logic             req0, req1, own_req;

    assign req0    = bus_rd_0 | bus_wr_0;
    assign req1    = bus_rd_1 | bus_wr_1;
    assign own_req = (state == Q_GNT0) ? req0 : req1;
    assign gnt     = state[2:1];

    // Completion takes priority over an abort seen in the same cycle.
    always_comb begin
        state_nxt = state;
        rr_nxt    = rr;
        cnt_nxt   = cnt;
        err_nxt   = 1'b0;
        case (state)
            Q_GNT0, Q_GNT1: begin
                if (mem_done) begin
                    state_nxt = Q_IDLE;
                    rr_nxt    = state[1];
                end else if (!own_req) begin
                    state_nxt = Q_IDLE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_nxt = Q_IDLE;
                    rr_nxt    = state[1];
                    err_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = Q_IDLE;
                cnt_nxt   = '0;
                if (req0 && (!req1 || !rr)) begin
                    state_nxt = Q_GNT0;
                end else if (req1) begin
                    state_nxt = Q_GNT1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= Q_IDLE;
            rr          <= 1'b0;
            cnt         <= '0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            rr          <= rr_nxt;
            cnt         <= cnt_nxt;
            err_timeout <= err_nxt;
        end
    end

    // Memory and bus sides follow the granted requester's live inputs.
    always_comb begin
        memread    = 1'b0;
        memwrite   = 1'b0;
        addr       = '0;
        wdata      = '0;
        bus_din_0  = '0;
        bus_din_1  = '0;
        bus_done_0 = 1'b0;
        bus_done_1 = 1'b0;
        if (state == Q_GNT0) begin
            memwrite   = bus_wr_0;
            memread    = bus_rd_0 & ~bus_wr_0;
            addr       = bus_addr_0;
            wdata      = bus_dout_0;
            bus_din_0  = rdata;
            bus_done_0 = mem_done;
        end else if (state == Q_GNT1) begin
            memwrite   = bus_wr_1;
            memread    = bus_rd_1 & ~bus_wr_1;
            addr       = bus_addr_1;
            wdata      = bus_dout_1;
            bus_din_1  = rdata;
            bus_done_1 = mem_done;
        end
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, memory block-address width.
REQ-002 SHALL have parameter DATA_W, default 16, memory block (two-byte line) width.
REQ-003 SHALL have parameter TIMEOUT, default 15, max cycles a grant waits for mem_done.
REQ-004 SHALL have ports: clk  in  1  single clock, rising edge; rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have, per requester k in {0,1}: bus_rd_k in 1 read request; bus_wr_k in 1 write request; bus_addr_k in ADDR_W block address; bus_dout_k in DATA_W write data; bus_din_k out DATA_W read data; bus_done_k out 1 completion pulse.
REQ-006 SHALL have memory side: memread out 1; memwrite out 1; addr out ADDR_W; wdata out DATA_W; rdata in DATA_W; mem_done in 1 memory completion.
REQ-007 SHALL have status outputs: gnt out 2 one-hot current grant; err_timeout out 1 one-cycle timeout pulse.

Function
REQ-008 SHALL use one-hot states QIdle=3'b001, QGnt0=3'b010, QGnt1=3'b100.
REQ-009 SHALL treat requester k as requesting when bus_rd_k|bus_wr_k; if both asserted, write wins and memread SHALL stay 0.
REQ-010 SHALL, in QIdle, grant on the next edge: sole requester wins; both requesting -> requester selected by round-robin pointer rr wins.
REQ-011 SHALL, in QGntk, drive memread/memwrite/addr/wdata combinationally from requester k's live inputs; in QIdle all memory outputs SHALL be 0.
REQ-012 SHALL route rdata to bus_din_k of the granted requester only; non-granted bus_din SHALL be 0.
REQ-013 SHALL assert bus_done_k combinationally equal to mem_done while in QGntk; mem_done in QIdle SHALL be ignored.
REQ-014 SHALL, on mem_done in QGntk, return to QIdle next edge and set rr to the other requester (no back-to-back grant to same requester when the other waits).
REQ-015 SHALL hold the grant while the requester holds its request; requester deasserting both rd and wr before mem_done SHALL abort: QIdle next edge, no bus_done, rr unchanged.
REQ-016 SHALL count cycles in QGntk with a 4-bit-or-wider counter cleared on grant; reaching TIMEOUT without mem_done SHALL pulse err_timeout one cycle, return to QIdle, and advance rr.
REQ-017 SHALL give minimum latency: request at edge N -> grant at N+1 -> earliest bus_done in cycle N+1 if memory completes same cycle.
REQ-018 SHALL insert exactly one QIdle cycle between consecutive grants (bus turnaround).
REQ-019 gnt SHALL equal state bits [2:1].

Reset
REQ-020 SHALL, on rst low, asynchronously force state=QIdle, rr=0, timeout counter=0, err_timeout=0.
REQ-021 SHALL drive all memory outputs, bus_done_k, bus_din_k and gnt to 0 while in reset, including reset asserted mid-grant (transaction dropped, no done).
REQ-022 SHALL begin arbitration on the first rising clk edge after rst rises.

Structure
REQ-023 SHALL place state encodings, ADDR_W/DATA_W defaults and TIMEOUT default in the shared cache package used by the cache controller.
REQ-024 SHALL be a single module with no sub-modules; the existing Memory model is the bench's memory-side target.

Verification
REQ-025 Single read: requester0 bus_rd_0=1, addr=0 -> gnt=2'b01 one cycle later, bus_din_0=16'h0100 with bus_done_0, then QIdle.
REQ-026 Collision after reset: both request same edge (rd addr=4 / wr 16'h0c0d addr=6) -> requester0 served first, one QIdle cycle, then requester1; mem[6] reads back 16'h0c0d.
REQ-027 Fairness: both hold requests for four transactions -> grant sequence 0,1,0,1; no bus_done to a non-granted requester.
REQ-028 Rd+wr together: bus_rd_1=bus_wr_1=1, wdata 16'h1105 addr=2 -> memwrite=1, memread=0, mem[2]=16'h1105.
REQ-029 Timeout: mem_done tied 0 -> err_timeout pulses exactly at cycle TIMEOUT (15) after grant, state QIdle, rr advanced.
REQ-030 Reset mid-grant: rst low during QGnt1 -> memread/memwrite/gnt 0 immediately (asynchronously), no bus_done_1, rr=0 after release.
